pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and flush sequencer for the 5-stage RV32 pipeline (fetch, decode, execute, memory, write-back). It watches decode/execute register usage, the memory-stage redirect and the memory-stage slow-device handshake. It drives per-stage stall, freeze and kill (bubble-insert) controls for the PC and the F_D/D_E/E_M/M_W pipeline registers. Forwarding stays in the datapath; this block covers only what forwarding cannot resolve.

## Interface
- FLUSH_CYCLES, 2: total cycles kill_fd is held after a redirect (≥1; covers synchronous-BRAM fetch latency).
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before forced abort (≥1).
- CNT_W, 32: performance counter width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_ra1, d_ra2  in  5  rs1/rs2 of the instruction in decode.
- d_use_rs1, d_use_rs2  in  1  decode instruction actually reads rs1/rs2.
- e_wa  in  5  rd of the instruction in execute.
- e_is_load  in  1  execute instruction is a load (WBSel = mem).
- e_regwen  in  1  execute instruction writes rd.
- redirect  in  1  taken branch/jump resolved in memory stage (PC takes E_M_alu).
- mem_req  in  1  memory-stage access to a slow (MMIO) target.
- mem_ready  in  1  slow target completes this cycle.
- stall_pc  out  1  PC holds.
- hold_fd  out  1  F_D holds.
- kill_fd  out  1  F_D loads NOP at next edge.
- kill_de  out  1  D_E loads NOP (control zeroed, RegWen=0, MemRW=0).
- kill_em  out  1  E_M loads NOP.
- freeze  out  1  PC, F_D, D_E, E_M hold; M_W loads NOP.
- mem_err  out  1  one-cycle pulse: MEM_WAIT timed out.
- perf_lu_cnt, perf_fl_cnt, perf_mw_cnt  out  CNT_W  load-use stall, flush, and mem-wait cycle counts.

## Operation
- States: RUN, FLUSH, MEM_WAIT. Internal flush counter fcnt of width $clog2(FLUSH_CYCLES+1). Internal wait counter wcnt of width $clog2(MEM_TIMEOUT+1).
- Load-use hazard lu = e_is_load & e_regwen & (e_wa≠0) & ((d_use_rs1 & d_ra1==e_wa) | (d_use_rs2 & d_ra2==e_wa)).
- Per-cycle priority: rst > mem wait > redirect > load-use.
- RUN:
  - mem_req & !mem_ready → freeze=1, go MEM_WAIT, wcnt=1.
  - Else redirect → kill_fd, kill_de and kill_em all =1. If FLUSH_CYCLES>1, go FLUSH with fcnt=FLUSH_CYCLES-1.
  - Else lu → stall_pc=1, hold_fd=1, kill_de=1 for exactly that cycle; stay RUN.
- FLUSH:
  - kill_fd=1 each cycle; fcnt decrements; fcnt==1 → RUN next edge.
  - redirect again → all three kills, fcnt reloads FLUSH_CYCLES-1.
  - lu is evaluated as in RUN, and stall_pc/hold_fd/kill_de combine with kill_fd.
  - mem_req & !mem_ready → MEM_WAIT; fcnt frozen and FLUSH resumes afterwards (a saved-return bit records this).
- MEM_WAIT:
  - freeze=1 while mem_ready=0; all other outputs 0; redirect and lu ignored (the datapath is frozen, so they re-present afterwards).
  - mem_ready=1 → freeze=0 that cycle; next edge returns to RUN, or to FLUSH if entered from FLUSH.
  - wcnt==MEM_TIMEOUT with mem_ready=0 → next edge leaves as above, mem_err=1 for one cycle.
- freeze and stall/kill are never asserted together with conflicting meaning: when freeze=1, stall_pc/hold_fd/kill_* are 0.

## Timing
- stall_pc, hold_fd, kill_*, freeze: combinational from state and inputs, valid the same cycle, act at the next rising edge.
- mem_err: registered.
- Load-use costs exactly 1 bubble. Redirect costs 3 killed slots plus FLUSH_CYCLES-1 extra kill_fd cycles.
- Reset: while rst=1, all outputs 0. State=RUN, fcnt=wcnt=0, mem_err=0, and perf counters cleared at the edge. Reset mid-FLUSH or mid-MEM_WAIT abandons the sequence with no mem_err.
- mem_req with mem_ready=1 in the same cycle: no wait, no freeze.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - perf_lu_cnt increments on each lu stall cycle.
  - perf_fl_cnt increments on each cycle with kill_fd=1.
  - perf_mw_cnt increments on each freeze cycle.
  - All three saturate at 2^CNT_W-1.
- Undefined: the three ports remain and are tied to 0; no counter flops.

## Test plan
- Load-use: e_is_load=1, e_regwen=1, e_wa=5, d_ra1=5, d_use_rs1=1 → stall_pc=hold_fd=kill_de=1 for one cycle only. Same stimulus with e_wa=0 → no stall.
- Redirect, FLUSH_CYCLES=2: redirect pulse at cycle N → kill_fd/kill_de/kill_em=1 at N, kill_fd=1 at N+1, all 0 at N+2.
- Slow access: mem_req=1, mem_ready low 4 cycles then high → freeze=1 for 4 cycles, 0 on the ready cycle, mem_err never asserted. With HAZARD_PERF_CNT_EN, perf_mw_cnt=4.
- Timeout, MEM_TIMEOUT=3: mem_req=1, mem_ready=0 forever → freeze for 3 cycles, then mem_err single pulse, state RUN.
- Simultaneous events: redirect and lu in the same cycle → kill_fd/kill_de/kill_em=1, stall_pc=0. mem_req & !mem_ready plus redirect → freeze only; redirect is serviced the cycle after mem_ready.
- Reset mid-sequence: rst=1 during MEM_WAIT cycle 2 → next cycle all outputs 0, no mem_err, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flush sequencer for the 5-stage RV32 pipeline: load-use stalls, redirect flushes, slow-memory freeze.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_ra1,
    input  logic [4:0]       d_ra2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_wa,
    input  logic             e_is_load,
    input  logic             e_regwen,
    input  logic             redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             hold_fd,
    output logic             kill_fd,
    output logic             kill_de,
    output logic             kill_em,
    output logic             freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_fl_cnt,
    output logic [CNT_W-1:0] perf_mw_cnt
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FW-1:0] F_ONE    = FW'(1);
    localparam logic [FW-1:0] F_RELOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] W_ONE    = WW'(1);
    localparam logic [WW-1:0] W_MAX    = WW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

    state_t        state, state_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic          ret_flush, ret_flush_nx;
    logic          mem_err_q, mem_err_nx;
    logic          lu, mem_stall;
    logic          stall_c, hold_c, kfd_c, kde_c, kem_c, frz_c;

    assign lu = e_is_load & e_regwen & (e_wa != 5'd0) &
                ((d_use_rs1 & (d_ra1 == e_wa)) | (d_use_rs2 & (d_ra2 == e_wa)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_nx     = state;
        fcnt_nx      = fcnt;
        wcnt_nx      = wcnt;
        ret_flush_nx = ret_flush;
        mem_err_nx   = 1'b0;
        stall_c      = 1'b0;
        hold_c       = 1'b0;
        kfd_c        = 1'b0;
        kde_c        = 1'b0;
        kem_c        = 1'b0;
        frz_c        = 1'b0;
        case (state)
            RUN, FLUSH: begin
                if (mem_stall) begin
                    frz_c        = 1'b1;
                    state_nx     = MEM_WAIT;
                    wcnt_nx      = W_ONE;
                    ret_flush_nx = (state == FLUSH);
                end else if (redirect) begin
                    kfd_c = 1'b1;
                    kde_c = 1'b1;
                    kem_c = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx = FLUSH;
                        fcnt_nx  = F_RELOAD;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    if (state == FLUSH) begin
                        kfd_c   = 1'b1;
                        fcnt_nx = fcnt - F_ONE;
                        if (fcnt == F_ONE) state_nx = RUN;
                    end
                    if (lu) begin
                        stall_c = 1'b1;
                        hold_c  = 1'b1;
                        kde_c   = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                // The abort cycle releases freeze just like a ready cycle, so the stuck access drains.
                if (mem_ready || wcnt == W_MAX) begin
                    state_nx   = ret_flush ? FLUSH : RUN;
                    wcnt_nx    = '0;
                    mem_err_nx = ~mem_ready;
                end else begin
                    frz_c   = 1'b1;
                    wcnt_nx = wcnt + W_ONE;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fcnt      <= '0;
            wcnt      <= '0;
            ret_flush <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            fcnt      <= fcnt_nx;
            wcnt      <= wcnt_nx;
            ret_flush <= ret_flush_nx;
            mem_err_q <= mem_err_nx;
        end
    end

    assign stall_pc = stall_c & ~rst;
    assign hold_fd  = hold_c & ~rst;
    assign kill_fd  = kfd_c & ~rst;
    assign kill_de  = kde_c & ~rst;
    assign kill_em  = kem_c & ~rst;
    assign freeze   = frz_c & ~rst;
    assign mem_err  = mem_err_q & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] lu_cnt, fl_cnt, mw_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt <= '0;
            fl_cnt <= '0;
            mw_cnt <= '0;
        end else begin
            if (stall_pc && lu_cnt != '1) lu_cnt <= lu_cnt + CNT_W'(1);
            if (kill_fd && fl_cnt != '1)  fl_cnt <= fl_cnt + CNT_W'(1);
            if (freeze && mw_cnt != '1)   mw_cnt <= mw_cnt + CNT_W'(1);
        end
    end

    assign perf_lu_cnt = rst ? '0 : lu_cnt;
    assign perf_fl_cnt = rst ? '0 : fl_cnt;
    assign perf_mw_cnt = rst ? '0 : mw_cnt;
`else
    assign perf_lu_cnt = '0;
    assign perf_fl_cnt = '0;
    assign perf_mw_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4, CNT_W=3).
module tb_pipe_hazard_ctrl;
    localparam int CW = 3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    // Output vector order: {stall_pc, hold_fd, kill_fd, kill_de, kill_em, freeze, mem_err}
    localparam logic [6:0] Z  = 7'b0000000;
    localparam logic [6:0] L  = 7'b1101000;
    localparam logic [6:0] R  = 7'b0011100;
    localparam logic [6:0] F  = 7'b0010000;
    localparam logic [6:0] FL = 7'b1111000;
    localparam logic [6:0] FZ = 7'b0000010;
    localparam logic [6:0] EL = 7'b1101001;

    // Stimulus vector: {rst, redirect, mem_req, mem_ready, lu_mode[2:0]}
    localparam logic [6:0] S_IDLE = 7'b0_0_0_0_000;
    localparam logic [6:0] S_LU   = 7'b0_0_0_0_001;
    localparam logic [6:0] S_RED  = 7'b0_1_0_0_000;
    localparam logic [6:0] S_REQ  = 7'b0_0_1_0_000;
    localparam logic [6:0] S_RDY  = 7'b0_0_1_1_000;

    logic clk = 1'b0;
    logic rst, redirect, mem_req, mem_ready;
    logic [4:0] d_ra1, d_ra2, e_wa;
    logic d_use_rs1, d_use_rs2, e_is_load, e_regwen;
    logic stall_pc, hold_fd, kill_fd, kill_de, kill_em, freeze, mem_err;
    logic [CW-1:0] perf_lu_cnt, perf_fl_cnt, perf_mw_cnt;
    logic [6:0] outs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {stall_pc, hold_fd, kill_fd, kill_de, kill_em, freeze, mem_err};

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .e_wa(e_wa),
        .e_is_load(e_is_load), .e_regwen(e_regwen), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .stall_pc(stall_pc),
        .hold_fd(hold_fd), .kill_fd(kill_fd), .kill_de(kill_de),
        .kill_em(kill_em), .freeze(freeze), .mem_err(mem_err),
        .perf_lu_cnt(perf_lu_cnt), .perf_fl_cnt(perf_fl_cnt), .perf_mw_cnt(perf_mw_cnt)
    );

    // lu_mode: 1 rs1 hazard, 2 rs2 hazard, 3 rd=x0, 4 no regwen, 5 rs1 unused, 6 not a load
    task automatic apply(input logic [6:0] s);
        rst = s[6]; redirect = s[5]; mem_req = s[4]; mem_ready = s[3];
        e_is_load = 1'b0; e_regwen = 1'b0; e_wa = 5'd5;
        d_ra1 = 5'd5; d_ra2 = 5'd7; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
        case (s[2:0])
            3'd1: begin e_is_load = 1'b1; e_regwen = 1'b1; d_use_rs1 = 1'b1; end
            3'd2: begin e_is_load = 1'b1; e_regwen = 1'b1; e_wa = 5'd7; d_ra1 = 5'd3;
                        d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; end
            3'd3: begin e_is_load = 1'b1; e_regwen = 1'b1; e_wa = 5'd0; d_ra1 = 5'd0;
                        d_use_rs1 = 1'b1; end
            3'd4: begin e_is_load = 1'b1; d_use_rs1 = 1'b1; end
            3'd5: begin e_is_load = 1'b1; e_regwen = 1'b1; d_use_rs2 = 1'b1; d_ra2 = 5'd6; end
            3'd6: begin e_regwen = 1'b1; d_use_rs1 = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic do_reset;
        apply(7'b1_0_0_0_000);
        @(posedge clk); #1;
        apply(S_IDLE);
    endtask

    task automatic test_reset;
        apply(7'b1_1_1_0_001);
        @(posedge clk); #1;
        @(posedge clk); #3;
        if (outs !== Z) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, Z); end
        checks++;
        if ({perf_lu_cnt, perf_fl_cnt, perf_mw_cnt} !== '0) begin
            errors++; $display("FAIL reset_perf got %h %h %h exp 0", perf_lu_cnt, perf_fl_cnt, perf_mw_cnt);
        end
        checks++;
        @(posedge clk); #1;
        apply(S_IDLE);
        #3;
        if (outs !== Z) begin errors++; $display("FAIL reset_idle got %b exp %b", outs, Z); end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use;
        logic [6:0] st [8];
        logic [6:0] ex [8];
        st = '{S_LU, S_IDLE, 7'd2, S_IDLE, 7'd3, 7'd4, 7'd5, 7'd6};
        ex = '{L, Z, L, Z, Z, Z, Z, Z};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL load_use[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
        if (perf_lu_cnt !== (PERF_EN ? 3'd2 : 3'd0)) begin
            errors++; $display("FAIL perf_lu got %0d exp %0d", perf_lu_cnt, PERF_EN ? 2 : 0);
        end
        checks++;
    endtask

    task automatic test_redirect;
        logic [6:0] st [3];
        logic [6:0] ex [3];
        st = '{S_RED, S_IDLE, S_IDLE};
        ex = '{R, F, Z};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL redirect[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
        if (perf_fl_cnt !== (PERF_EN ? 3'd2 : 3'd0)) begin
            errors++; $display("FAIL perf_fl got %0d exp %0d", perf_fl_cnt, PERF_EN ? 2 : 0);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        logic [6:0] st [4];
        logic [6:0] ex [4];
        st = '{S_RED, S_RED, S_IDLE, S_IDLE};
        ex = '{R, R, F, Z};
        for (int i = 0; i < 4; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL back_to_back[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_lu;
        logic [6:0] st [3];
        logic [6:0] ex [3];
        st = '{S_RED | S_LU, S_LU, S_IDLE};
        ex = '{R, FL, Z};
        for (int i = 0; i < 3; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL redirect_lu[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_slow_access;
        logic [6:0] st [8];
        logic [6:0] ex [8];
        st = '{S_REQ, S_REQ, S_REQ, S_REQ, S_RDY, S_IDLE, S_RDY, S_IDLE};
        ex = '{FZ, FZ, FZ, FZ, Z, Z, Z, Z};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL slow_access[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
        if (perf_mw_cnt !== (PERF_EN ? 3'd4 : 3'd0)) begin
            errors++; $display("FAIL perf_mw got %0d exp %0d", perf_mw_cnt, PERF_EN ? 4 : 0);
        end
        checks++;
    endtask

    task automatic test_timeout;
        logic [6:0] st [7];
        logic [6:0] ex [7];
        st = '{S_REQ, S_REQ, S_REQ, S_REQ, S_REQ, S_LU, S_IDLE};
        ex = '{FZ, FZ, FZ, FZ, Z, EL, Z};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL timeout[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_redirect;
        logic [6:0] st [6];
        logic [6:0] ex [6];
        st = '{S_REQ | S_RED, S_REQ | S_RED, S_RDY | S_RED, S_RED, S_IDLE, S_IDLE};
        ex = '{FZ, FZ, Z, R, F, Z};
        for (int i = 0; i < 6; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL mem_redirect[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_mem;
        logic [6:0] st [5];
        logic [6:0] ex [5];
        st = '{S_RED, S_REQ, S_RDY, S_IDLE, S_IDLE};
        ex = '{R, FZ, Z, F, Z};
        for (int i = 0; i < 5; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL flush_mem[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        logic [6:0] st [7];
        logic [6:0] ex [7];
        st = '{S_REQ, S_REQ, 7'b1_0_1_0_000, S_IDLE, S_IDLE, S_IDLE, S_IDLE};
        ex = '{FZ, FZ, Z, Z, Z, Z, Z};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply(st[i]); #3;
            if (outs !== ex[i]) begin errors++; $display("FAIL reset_mid[%0d] got %b exp %b", i, outs, ex[i]); end
            checks++;
            @(posedge clk); #1;
        end
        if ({perf_lu_cnt, perf_fl_cnt, perf_mw_cnt} !== '0) begin
            errors++; $display("FAIL reset_mid_perf got %h %h %h exp 0", perf_lu_cnt, perf_fl_cnt, perf_mw_cnt);
        end
        checks++;
    endtask

    task automatic test_saturate;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(S_LU); #3;
            if (outs !== L) begin errors++; $display("FAIL saturate_lu[%0d] got %b exp %b", i, outs, L); end
            checks++;
            @(posedge clk); #1;
        end
        apply(S_IDLE);
        if (perf_lu_cnt !== (PERF_EN ? 3'd7 : 3'd0)) begin
            errors++; $display("FAIL perf_lu_sat got %0d exp %0d", perf_lu_cnt, PERF_EN ? 7 : 0);
        end
        checks++;
    endtask

    initial begin
        apply(7'b1_0_0_0_000);
        test_reset();
        test_load_use();
        test_redirect();
        test_back_to_back();
        test_redirect_lu();
        test_slow_access();
        test_timeout();
        test_mem_redirect();
        test_flush_mem();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
